// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, R/W bit encoding and byte framing constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX       = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX       = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Bit counter value at the start of a byte (MSB first, counts down and wraps 7->0).
    localparam logic [2:0] I2C_BIT_MSB = 3'd7;
    // Bit index driven next after the MSB has been put on the bus.
    localparam logic [2:0] I2C_BIT_AFTER_MSB = 3'd6;

endpackage

// File: rtl/i2c_bus_sampler.sv
// Synchronises raw SCL/SDA into the clk domain and derives SCL edge and START/STOP events.
module i2c_bus_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_hist_reg;
    logic                   sda_hist_reg;
    logic                   scl_level;

    // Synchronisers reset to the idle-bus level so no false event fires after reset.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        scl_sync_reg[gi] <= 1'b1;
                        sda_sync_reg[gi] <= 1'b1;
                    end else begin
                        scl_sync_reg[gi] <= scl_in;
                        sda_sync_reg[gi] <= sda_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        scl_sync_reg[gi] <= 1'b1;
                        sda_sync_reg[gi] <= 1'b1;
                    end else begin
                        scl_sync_reg[gi] <= scl_sync_reg[gi-1];
                        sda_sync_reg[gi] <= sda_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_hist_reg <= scl_level;
            sda_hist_reg <= sda_level;
        end
    end

    assign scl_level = scl_sync_reg[SYNC_STAGES-1];
    assign sda_level = sda_sync_reg[SYNC_STAGES-1];

    assign scl_rise = scl_level & ~scl_hist_reg;
    assign scl_fall = ~scl_level & scl_hist_reg;
    // SDA may only move while SCL is low; a move with SCL high (now and before) is START/STOP.
    assign start    = scl_level & scl_hist_reg & sda_hist_reg & ~sda_level;
    assign stop     = scl_level & scl_hist_reg & ~sda_hist_reg & sda_level;

endmodule

// File: rtl/i2c_target.sv
// I2C target engine: address match, ACK generation, byte receive and transmit with a
// valid/request handshake to user logic. Never drives SCL.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic       busy,
    output logic       read_write,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       tx_nack
);

    logic sda_level;
    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    i2c_bus_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_level(sda_level),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (bus_start),
        .stop     (bus_stop)
    );

    i2c_state_t state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_data_reg;
    logic       sda_oe_reg;
    logic       busy_reg;
    logic       read_write_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       tx_req_reg;
    logic       tx_nack_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= I2C_BIT_MSB;
            shift_data_reg <= 8'h00;
            sda_oe_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            read_write_reg <= I2C_RW_WRITE;
            rx_data_reg    <= 8'h00;
            rx_valid_reg   <= 1'b0;
            tx_req_reg     <= 1'b0;
            tx_nack_reg    <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            tx_req_reg   <= 1'b0;
            tx_nack_reg  <= 1'b0;

            if (bus_stop) begin
                sda_oe_reg <= 1'b0;
                busy_reg   <= 1'b0;
                state_reg  <= ST_IDLE;
            end else if (bus_start) begin
                sda_oe_reg  <= 1'b0;
                busy_reg    <= 1'b0;
                bit_cnt_reg <= I2C_BIT_MSB;
                state_reg   <= ST_ADDR;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        sda_oe_reg <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_data_reg <= {shift_data_reg[6:0], sda_level};
                            bit_cnt_reg    <= bit_cnt_reg - 3'd1;
                            // On the 8th bit the address is in shift_data_reg[6:0], R/W on the wire.
                            if (bit_cnt_reg == 3'd0) begin
                                state_reg <= (shift_data_reg[6:0] == ADDRESS) ? ST_ADDR_ACK : ST_IGNORE;
                            end
                        end
                    end

                    // First SCL fall drives the ACK; the second ends the ACK bit.
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe_reg) begin
                                sda_oe_reg     <= 1'b1;
                                busy_reg       <= 1'b1;
                                read_write_reg <= shift_data_reg[0];
                            end else if (read_write_reg == I2C_RW_READ) begin
                                shift_data_reg <= tx_data;
                                sda_oe_reg     <= ~tx_data[7];
                                bit_cnt_reg    <= I2C_BIT_AFTER_MSB;
                                state_reg      <= ST_TX;
                            end else begin
                                sda_oe_reg  <= 1'b0;
                                bit_cnt_reg <= I2C_BIT_MSB;
                                state_reg   <= ST_RX;
                            end
                        end else if (scl_rise && sda_oe_reg && (read_write_reg == I2C_RW_READ)) begin
                            tx_req_reg <= 1'b1;
                        end
                    end

                    ST_RX: begin
                        if (scl_rise) begin
                            shift_data_reg <= {shift_data_reg[6:0], sda_level};
                            bit_cnt_reg    <= bit_cnt_reg - 3'd1;
                        end else if (scl_fall && (bit_cnt_reg == I2C_BIT_MSB)) begin
                            sda_oe_reg <= 1'b1;
                            state_reg  <= ST_RX_ACK;
                        end
                    end

                    ST_RX_ACK: begin
                        if (scl_rise) begin
                            rx_data_reg  <= shift_data_reg;
                            rx_valid_reg <= 1'b1;
                        end else if (scl_fall) begin
                            sda_oe_reg  <= 1'b0;
                            bit_cnt_reg <= I2C_BIT_MSB;
                            state_reg   <= ST_RX;
                        end
                    end

                    // bit_cnt_reg names the next bit to drive; wrapping to 7 means all 8 are out.
                    ST_TX: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == I2C_BIT_MSB) begin
                                sda_oe_reg <= 1'b0;
                                state_reg  <= ST_TX_ACK;
                            end else begin
                                sda_oe_reg  <= ~shift_data_reg[bit_cnt_reg];
                                bit_cnt_reg <= bit_cnt_reg - 3'd1;
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_level) begin
                                tx_req_reg <= 1'b1;
                            end else begin
                                tx_nack_reg <= 1'b1;
                                state_reg   <= ST_IGNORE;
                            end
                        end else if (scl_fall) begin
                            shift_data_reg <= tx_data;
                            sda_oe_reg     <= ~tx_data[7];
                            bit_cnt_reg    <= I2C_BIT_AFTER_MSB;
                            state_reg      <= ST_TX;
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe_reg <= 1'b0;
                    end

                    default: begin
                        sda_oe_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_out    = 1'b0;
    assign sda_oe     = sda_oe_reg;
    assign busy       = busy_reg;
    assign read_write = read_write_reg;
    assign rx_data    = rx_data_reg;
    assign rx_valid   = rx_valid_reg;
    assign tx_req     = tx_req_reg;
    assign tx_nack    = tx_nack_reg;

endmodule
